// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu front end: fetch FSM states and
// instruction-word field layout.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [1:0] TYPE_NOP   = 2'b00;
    localparam logic [1:0] TYPE_STD   = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;
    localparam logic [1:0] TYPE_STORE = 2'b11;

    localparam int TYPE_MSB = 19;
    localparam int TYPE_LSB = 18;

endpackage

// File: rtl/instr_mem.sv
// Single-port instruction store: synchronous write, registered read with
// write-to-read forwarding so a word loaded on the fetch-launch edge is seen.
module instr_mem #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [PC_BITS-1:0]     wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [PC_BITS-1:0]     rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** PC_BITS;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose: the program must survive rst,
    // and a reset would also prevent mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable program store, PC, issue counter and a
// four-state FSM handing one instruction at a time to the control unit.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int CNT_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    input  logic                   next,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   halted,
    output logic [CNT_BITS-1:0]    issue_cnt
);

    fetch_state_t           state, state_nxt;
    logic                   load_ok;
    logic                   go_fetch;
    logic [PC_BITS-1:0]     fetch_addr;
    logic [INSTR_WIDTH-1:0] word;
    logic                   is_nop;

    // The read is launched on the edge entering FETCH, so word is mem[pc]
    // throughout the FETCH cycle.
    instr_mem #(
        .INSTR_WIDTH(INSTR_WIDTH),
        .PC_BITS    (PC_BITS)
    ) u_mem (
        .clk    (clk),
        .wr_en  (load_ok && load_en),
        .wr_addr(load_addr),
        .wr_data(load_data),
        .rd_en  (go_fetch),
        .rd_addr(fetch_addr),
        .rd_data(word)
    );

    assign is_nop = (word[TYPE_MSB:TYPE_LSB] == TYPE_NOP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALTED: if (start) state_nxt = FETCH;
            FETCH:        state_nxt = is_nop ? HALTED : ISSUE;
            ISSUE:        if (next) state_nxt = FETCH;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ok    = 1'b0;
        go_fetch   = 1'b0;
        fetch_addr = '0;
        if (!rst) begin
            load_ok  = (state == IDLE) || (state == HALTED);
            go_fetch = (load_ok && start) || ((state == ISSUE) && next);
        end
        if (state == ISSUE) begin
            fetch_addr = pc + PC_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            issue_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) pc <= '0;
                end
                HALTED: begin
                    if (start) begin
                        pc        <= '0;
                        halted    <= 1'b0;
                        issue_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (is_nop) begin
                        halted      <= 1'b1;
                        instr_valid <= 1'b0;
                        instr       <= '0;
                    end else begin
                        instr       <= word;
                        instr_valid <= 1'b1;
                        if (issue_cnt != '1) issue_cnt <= issue_cnt + CNT_BITS'(1);
                    end
                end
                ISSUE: begin
                    if (next) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + PC_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model predicts each issue
// or halt event; a monitor compares them as the DUT presents them.
module tb_instr_fetch;

    localparam int IW = 20;
    localparam int PB = 5;
    localparam int CB = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [PB-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic          next = 1'b0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [PB-1:0] pc;
    logic          halted;
    logic [CB-1:0] issue_cnt;

    always #5 clk = ~clk;

    instr_fetch #(.INSTR_WIDTH(IW), .PC_BITS(PB), .CNT_BITS(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .next       (next),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .halted     (halted),
        .issue_cnt  (issue_cnt)
    );

    typedef struct {
        bit            is_halt;
        logic [IW-1:0] instr;
        logic [PB-1:0] pc;
        logic [CB-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   tests = 0;
    int   fails = 0;

    // Program-level reference model
    logic [IW-1:0] model_mem [DEPTH];
    int            model_pc = 0;
    int            model_cnt = 0;
    bit            model_running = 0;
    bit            model_halted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic summary_and_finish();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic model_fetch();
        logic [IW-1:0] w;
        exp_t e;
        w = model_mem[model_pc];
        if (w[19:18] == 2'b00) begin
            e.is_halt = 1'b1;
            e.instr = '0;
            model_running = 0;
            model_halted = 1;
        end else begin
            model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
            e.is_halt = 1'b0;
            e.instr = w;
        end
        e.pc = PB'(model_pc);
        e.cnt = CB'(model_cnt);
        last_e = e;
        exp_q.push_back(e);
    endtask

    task automatic model_start();
        if (model_halted) model_cnt = 0;
        model_halted = 0;
        model_running = 1;
        model_pc = 0;
        model_fetch();
    endtask

    task automatic model_next();
        model_pc = (model_pc + 1) % DEPTH;
        model_fetch();
    endtask

    task automatic model_reset();
        model_pc = 0;
        model_cnt = 0;
        model_running = 0;
        model_halted = 0;
    endtask

    // Drivers: entered and left just after a falling edge.
    task automatic do_load(input int a, input logic [IW-1:0] d);
        load_en = 1'b1;
        load_addr = PB'(a);
        load_data = d;
        if (!model_running) model_mem[a] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_load_start(input int a, input logic [IW-1:0] d);
        load_en = 1'b1;
        load_addr = PB'(a);
        load_data = d;
        start = 1'b1;
        model_mem[a] = d;
        model_start();
        @(negedge clk);
        load_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_next(input bit with_start);
        next = 1'b1;
        start = with_start;
        model_next();
        @(negedge clk);
        next = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_event();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_valid || halted) return;
        end
        check("wait for valid/halted timed out", 32'd0, 32'd1);
        summary_and_finish();
    endtask

    task automatic run_to_halt();
        for (int k = 0; k < 40; k++) begin
            wait_event();
            if (halted) return;
            repeat (3) @(negedge clk);
            do_next(1'b0);
        end
        check("program reached halt", {31'b0, halted}, 32'd1);
    endtask

    function automatic logic [IW-1:0] rand_word();
        return {2'($urandom_range(1, 3)), 18'($urandom)};
    endfunction

    // Monitor: every rising instr_valid or halted is one predicted event.
    bit pv = 0, ph = 0;
    always @(negedge clk) begin
        exp_t e;
        if ((instr_valid && !pv) || (halted && !ph)) begin
            check("event predicted", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid/halted", {30'b0, instr_valid, halted}, e.is_halt ? 32'd1 : 32'd2);
                check("instr", instr, e.instr);
                check("pc", pc, e.pc);
                check("issue_cnt", issue_cnt, e.cnt);
            end
        end
        pv = instr_valid;
        ph = halted;
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset pc", pc, 0);
        check("reset instr", instr, 0);
        check("reset instr_valid", instr_valid, 0);
        check("reset halted", halted, 0);
        check("reset issue_cnt", issue_cnt, 0);

        // Basic program, long hold in ISSUE, ignored load while running
        do_load(0, 20'h42100);
        do_load(1, 20'h84050);
        do_load(2, 20'h00000);
        do_start();
        wait_event();
        for (int i = 0; i < 10; i++) begin
            check("hold instr", instr, last_e.instr);
            check("hold pc", pc, last_e.pc);
            check("hold valid", instr_valid, 1);
            check("hold issue_cnt", issue_cnt, last_e.cnt);
            @(negedge clk);
        end
        do_load(1, 20'h00000);
        do_next(1'b0);
        run_to_halt();
        check("halt flag", halted, 1);
        check("halt valid", instr_valid, 0);
        check("halt issue_cnt", issue_cnt, 2);

        // Load and start together from HALTED
        do_load_start(0, 20'h50001);
        wait_event();
        check("load+start instr", instr, 20'h50001);
        check("load+start halted", halted, 0);
        run_to_halt();

        // Reset during ISSUE at pc 3; program preserved
        for (int a = 0; a < 5; a++) do_load(a, rand_word());
        do_load(5, {2'b00, 18'($urandom)});
        do_start();
        for (int i = 0; i < 3; i++) begin
            wait_event();
            do_next(1'b0);
        end
        wait_event();
        check("pc before rst", pc, 3);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("rst pc", pc, 0);
        check("rst instr", instr, 0);
        check("rst instr_valid", instr_valid, 0);
        check("rst halted", halted, 0);
        check("rst issue_cnt", issue_cnt, 0);
        check("no pending events after rst", exp_q.size(), 0);
        do_start();
        wait_event();
        check("refetch mem[0]", instr, model_mem[0]);
        run_to_halt();

        // Full memory, continuous next: pc wrap and counter saturation
        for (int a = 0; a < DEPTH; a++) do_load(a, rand_word());
        do_start();
        for (int i = 0; i < 300; i++) begin
            wait_event();
            if (i == 32) begin
                check("wrap pc", pc, 0);
                check("wrap issue_cnt", issue_cnt, 33);
            end
            do_next($urandom_range(0, 3) == 0);
        end
        wait_event();
        check("saturated issue_cnt", issue_cnt, 255);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        repeat (5) @(negedge clk);
        check("all predicted events seen", exp_q.size(), 0);
        summary_and_finish();
    end

endmodule
